cpu_bus_sequencer: RTL
======================

Name: cpu_bus_sequencer

Overview:
- Upstream control stage for the 4-bit datapath: accepts one transfer/ALU micro-op at a time through a valid/ready handshake.
- Computes the 4-bit value for each op, drives it on the shared bus, and pulses exactly one register's load-enable for one cycle.
- Its `bus` and `reg_en` outputs feed the `inputD`/`enable` pins of the datapath's 4-bit registers; their Q outputs return packed on `reg_q`.

Parameters:
- NUM_REGS, 4, number of 4-bit registers addressed (legal 2..4); register indices are always 2 bits wide.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- req_valid  input  1  micro-op request present.
- req_ready  output  1  sequencer can accept a request this cycle.
- req_op  input  2  00 MOV src->dst, 01 LDI imm->dst, 10 ADD dst<=dst+src, 11 CLR dst<=0.
- req_src  input  2  source register index (MOV/ADD only).
- req_dst  input  2  destination register index.
- req_imm  input  4  immediate value (LDI only).
- reg_q  input  4*NUM_REGS  packed register outputs; register i occupies bits [4i+3:4i].
- bus  output  4  shared data bus, feeds register D inputs.
- reg_en  output  NUM_REGS  one-hot load enables, feed register enable inputs.
- done  output  1  one-cycle pulse when an op retires.
- err  output  1  one-cycle pulse with done when dst (or src for MOV/ADD) is >= NUM_REGS.
- carry  output  1  carry-out of the last retired ADD (see Optional Feature).
- zero  output  1  1 when the last retired value was 0000 (see Optional Feature).

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; bus=0000, reg_en=0, done=0, err=0, carry=0, zero=0; latched op fields cleared.
  - req_ready is 0 during reset and 1 in the first cycle after release.
  - Reset mid-operation aborts the op: no reg_en pulse, no done.
- States: IDLE -> LATCH -> DRIVE -> LOAD -> RETIRE -> IDLE.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid&&req_ready at posedge: op, src, dst, imm are latched and the state moves to LATCH.
  - req_valid without ready is ignored and holds no state. Request fields may change freely after acceptance.
- LATCH:
  - req_ready=0.
  - Decode the op and range-check indices. An out-of-range index sets an internal error bit.
- DRIVE:
  - Sample reg_q and compute result into a 5-bit internal value:
    - MOV: result = src value.
    - LDI: result = imm.
    - ADD: result = {carry, sum} = dst value + src value, mod 16; carry = bit 4.
    - CLR: result = 0000.
  - bus = result[3:0]; reg_en = 0 (setup cycle).
- LOAD:
  - bus holds result.
  - reg_en[dst] = 1 for exactly this cycle, so the destination register captures at the end of LOAD.
  - If the error bit is set, reg_en stays 0 and the bus still shows the result.
- RETIRE:
  - bus = 0000, reg_en = 0.
  - done = 1; err = error bit.
  - carry/zero update on the RETIRE edge: carry only on ADD, held otherwise; zero on every non-error op.
- Latency: accept edge at cycle 0, LOAD in cycle 3, register updated at the end of cycle 3, done in cycle 4, req_ready again in cycle 5.
  - Back-to-back throughput: one op per 5 cycles.
- Outside DRIVE/LOAD the bus is 0000; reg_en is never multi-hot.
- Same-register ops are legal. MOV r1->r1 reloads its own value; ADD r2,r2 doubles it.
- Wrap-around: F+1 gives 0 with carry=1; 8+8 gives 0 with carry=1; 7+8 gives F with carry=0.

Optional Feature:
- Macro CPU_SEQ_FLAGS_EN.
- Defined: carry and zero flags are implemented as described above.
- Undefined:
  - carry and zero are tied to 0 and no flag registers are built.
  - ADD still wraps mod 16.
  - All other behaviour and timing are identical.

Test Plan:
- Reset then LDI dst=2 imm=A -> reg_en=0100 for exactly one cycle with bus=A, done at cycle 4, zero=0, req_ready back at cycle 5.
- With r0=F, r1=1: ADD src=1 dst=0 -> bus=0 during LOAD, reg_en=0001, carry=1, zero=1 after done (both 0 when the macro is undefined).
- MOV src=3 dst=1 with r3=5, then CLR dst=3 issued on the first ready cycle -> r1 gets 5, then r3 gets 0; req_valid held during busy cycles produces no extra accepts.
- NUM_REGS=2, LDI dst=3 imm=7 -> reg_en stays 00 throughout, done=1 and err=1 in the same cycle, flags unchanged.
- Reset driven low during the DRIVE cycle of an LDI -> no reg_en pulse, no done, all outputs 0; a fresh request is accepted after release.
- reg_q changes after DRIVE but before LOAD -> bus holds the value sampled in DRIVE.

Source files
------------

// File: rtl/cpu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_bus_sequencer
//
// Upstream control stage for the 4-bit datapath. It accepts one micro-op at a
// time over a valid/ready handshake and computes the 4-bit result. It drives
// that result on the shared bus and pulses exactly one register load-enable
// for one cycle. Each op takes five cycles from accept to ready again.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-low reset
//   req_valid  micro-op request present
//   req_ready  sequencer can accept a request this cycle
//   req_op     00 MOV src->dst, 01 LDI imm->dst, 10 ADD dst+=src, 11 CLR dst
//   req_src    source register index (MOV/ADD)
//   req_dst    destination register index
//   req_imm    immediate value (LDI)
//   reg_q      packed register outputs, register i at [4i+3:4i]
//   bus        shared data bus to the register D inputs
//   reg_en     one-hot register load enables
//   done       one-cycle pulse when an op retires
//   err        one-cycle pulse with done on an out-of-range index
//   carry      carry-out of the last retired ADD
//   zero       last retired value was 0000
//
// Optional feature macro: CPU_SEQ_FLAGS_EN
//   defined   -> carry/zero flag registers are built
//   undefined -> carry and zero are tied to 0; everything else is identical
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request; the handshake latches the op fields
// S_LATCH  | decode the op and range-check the indices
// S_DRIVE  | sample reg_q, compute the result, show it on the bus (setup)
// S_LOAD   | hold the bus, pulse reg_en[dst] unless the op is in error
// S_RETIRE | bus idle, pulse done (and err); flags update on this edge
module cpu_bus_sequencer #(
  parameter int NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [1:0]            req_src,
  input  logic [1:0]            req_dst,
  input  logic [3:0]            req_imm,
  input  logic [4*NUM_REGS-1:0] reg_q,
  output logic [3:0]            bus,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic                  done,
  output logic                  err,
  output logic                  carry,
  output logic                  zero
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  // Index compare is done at 3 bits so NUM_REGS=4 fits without overflow.
  localparam logic [2:0] NUM_REGS_W = 3'(NUM_REGS);

  // The carry bit of the result is only kept when flags are built.
`ifdef CPU_SEQ_FLAGS_EN
  localparam int RES_W = 5;
`else
  localparam int RES_W = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_DRIVE,
    S_LOAD,
    S_RETIRE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       dst_q, dst_d;
  logic [3:0]       imm_q, imm_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] result_q, result_d;

  logic                ready_c;
  logic [3:0]          bus_c;
  logic [NUM_REGS-1:0] en_c;
  logic                done_c;
  logic                err_c;

  logic [3:0] src_val;
  logic [3:0] dst_val;
  logic       uses_src;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      src_q    <= 2'b00;
      dst_q    <= 2'b00;
      imm_q    <= 4'h0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Register read mux. Out-of-range indices read as 0; such ops are flagged
  // as errors and never load a register.
  always_comb begin
    src_val = 4'h0;
    dst_val = 4'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_q == 2'(i)) src_val = reg_q[4*i +: 4];
      if (dst_q == 2'(i)) dst_val = reg_q[4*i +: 4];
    end
  end

  assign uses_src = (op_q == OP_MOV) || (op_q == OP_ADD);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    imm_d    = imm_q;
    err_d    = err_q;
    result_d = result_q;
    ready_c  = 1'b0;
    bus_c    = 4'h0;
    en_c     = '0;
    done_c   = 1'b0;
    err_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          src_d   = req_src;
          dst_d   = req_dst;
          imm_d   = req_imm;
          err_d   = 1'b0;
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        err_d   = ({1'b0, dst_q} >= NUM_REGS_W) ||
                  (uses_src && ({1'b0, src_q} >= NUM_REGS_W));
        state_d = S_DRIVE;
      end

      S_DRIVE: begin
        unique case (op_q)
          OP_MOV:  result_d = RES_W'(src_val);
          OP_LDI:  result_d = RES_W'(imm_q);
          OP_ADD:  result_d = RES_W'(dst_val) + RES_W'(src_val);
          OP_CLR:  result_d = '0;
          default: result_d = '0;
        endcase
        bus_c   = result_d[3:0];
        state_d = S_LOAD;
      end

      S_LOAD: begin
        // Bus comes from the value captured in DRIVE, so a reg_q change now
        // does not disturb the register being loaded.
        bus_c = result_q[3:0];
        for (int i = 0; i < NUM_REGS; i++) begin
          if (dst_q == 2'(i)) en_c[i] = !err_q;
        end
        state_d = S_RETIRE;
      end

      S_RETIRE: begin
        done_c  = 1'b1;
        err_c   = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and strobes are forced low while reset is asserted so that an
  // op caught mid-flight by reset can never load a register or retire.
  assign req_ready = reset & ready_c;
  assign bus       = reset ? bus_c : 4'h0;
  assign reg_en    = reset ? en_c : '0;
  assign done      = reset & done_c;
  assign err       = reset & err_c;

`ifdef CPU_SEQ_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Flags only move on a clean retire; an errored op leaves both untouched.
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if ((state_q == S_RETIRE) && !err_q) begin
      zero_d = (result_q[3:0] == 4'h0);
      if (op_q == OP_ADD) carry_d = result_q[4];
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`else
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

endmodule
